jtag_pattern_sequencer: RTL and testbench

- Upstream feeder for the TMS/TCK bit-banger.
- Buffers TMS pattern words written from the register interface in a small FIFO.
- On start, issues them to the bit-banger one at a time: presents `pattern`, asserts `go`, waits for `done`.
- Adds an optional inter-pattern gap, a watchdog timeout and abort, and reports status back to the register block.

---
 rtl/jtag_pkg.sv | 22 ++
 rtl/jtag_pattern_fifo.sv | 65 ++++++
 rtl/jtag_pattern_sequencer.sv | 163 ++++++++++++++++
 tb/tb_jtag_pattern_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG pattern sequencer and its register block.
package jtag_pkg;

    localparam int unsigned JTAG_PATTERN_WIDTH = 16;

    // Status word bit positions as seen by the register block
    localparam int unsigned STATUS_OVERFLOW_BIT = 0;
    localparam int unsigned STATUS_TIMEOUT_BIT  = 1;
    localparam int unsigned STATUS_ACTIVE_BIT   = 2;
    localparam int unsigned STATUS_FULL_BIT     = 3;
    localparam int unsigned STATUS_EMPTY_BIT    = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StGo,
        StWait,
        StGap,
        StNext
    } state_t;

endpackage

// File: rtl/jtag_pattern_fifo.sv
// Synchronous FIFO of TMS pattern words with occupancy count and a synchronous flush.
module jtag_pattern_fifo
    import jtag_pkg::*;
#(
    parameter int unsigned pWIDTH = JTAG_PATTERN_WIDTH,
    parameter int unsigned pDEPTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_flush,
    input  logic                      i_push,
    input  logic [pWIDTH-1:0]         i_data,
    input  logic                      i_pop,
    output logic [pWIDTH-1:0]         o_head,
    output logic [$clog2(pDEPTH):0]   o_count,
    output logic                      o_full,
    output logic                      o_empty
);

    localparam int unsigned AW = $clog2(pDEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(pDEPTH);

    logic [pWIDTH-1:0] r_mem [pDEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == FULL_COUNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // Flush wins over a coincident push or pop
    assign w_push = i_push && !o_full && !i_flush;
    assign w_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/jtag_pattern_sequencer.sv
// Feeds queued TMS pattern words to the bit-banger one at a time with go/done handshake,
// optional inter-pattern gap, watchdog timeout and abort.
module jtag_pattern_sequencer
    import jtag_pkg::*;
#(
    parameter int unsigned pPATTERN_WIDTH = JTAG_PATTERN_WIDTH,
    parameter int unsigned pDEPTH         = 8,
    parameter int unsigned pTIMEOUT_WIDTH = 16
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_wr_en,
    input  logic [pPATTERN_WIDTH-1:0]   i_wr_data,
    input  logic                        i_start,
    input  logic                        i_abort,
    input  logic                        i_clear_status,
    input  logic [7:0]                  i_gap_cycles,
    input  logic                        i_bb_busy,
    input  logic                        i_bb_done,
    output logic [pPATTERN_WIDTH-1:0]   o_bb_pattern,
    output logic                        o_bb_go,
    output logic                        o_bb_reset,
    output logic [$clog2(pDEPTH):0]     o_fifo_count,
    output logic                        o_fifo_full,
    output logic                        o_fifo_empty,
    output logic                        o_active,
    output logic                        o_seq_done,
    output logic [15:0]                 o_completed,
    output logic                        o_overflow,
    output logic                        o_timeout
);

    state_t                      r_state;
    logic [pTIMEOUT_WIDTH-1:0]   r_wdog;
    logic [7:0]                  r_gap_cnt;
    logic [pPATTERN_WIDTH-1:0]   r_bb_pattern;
    logic                        r_bb_go;
    logic                        r_bb_reset;
    logic                        r_seq_done;
    logic [15:0]                 r_completed;
    logic                        r_overflow;
    logic                        r_timeout;

    logic [pPATTERN_WIDTH-1:0]   w_head;
    logic [pTIMEOUT_WIDTH-1:0]   w_wdog_inc;
    logic                        w_in_handshake;
    logic                        w_done_seen;
    logic                        w_timeout_evt;
    logic                        w_flush;
    logic                        w_pop;

    // Expiry fires on the edge where the watchdog would reach all-ones; a done in the
    // same cycle still counts as seen in time.
    assign w_wdog_inc     = r_wdog + 1'b1;
    assign w_in_handshake = (r_state == StGo) || (r_state == StWait);
    assign w_done_seen    = (r_state == StWait) && i_bb_done;
    assign w_timeout_evt  = w_in_handshake && (w_wdog_inc == '1) && !w_done_seen && !i_abort;
    assign w_flush        = i_abort || w_timeout_evt;
    assign w_pop          = w_done_seen && !i_abort;

    jtag_pattern_fifo #(
        .pWIDTH (pPATTERN_WIDTH),
        .pDEPTH (pDEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (w_flush),
        .i_push  (i_wr_en),
        .i_data  (i_wr_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (o_fifo_count),
        .o_full  (o_fifo_full),
        .o_empty (o_fifo_empty)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_wdog       <= '0;
            r_gap_cnt    <= '0;
            r_bb_pattern <= '0;
            r_bb_go      <= 1'b0;
            r_bb_reset   <= 1'b0;
            r_seq_done   <= 1'b0;
            r_completed  <= '0;
            r_overflow   <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_bb_reset <= 1'b0;
            r_seq_done <= 1'b0;

            if (i_wr_en && o_fifo_full) r_overflow <= 1'b1;
            else if (i_clear_status)    r_overflow <= 1'b0;

            if (w_timeout_evt)       r_timeout <= 1'b1;
            else if (i_clear_status) r_timeout <= 1'b0;

            if (w_flush) begin
                r_bb_go    <= 1'b0;
                r_bb_reset <= 1'b1;
                r_state    <= StIdle;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (i_start && !o_fifo_empty) begin
                            r_completed <= '0;
                            r_state     <= StLoad;
                        end
                    end
                    StLoad: begin
                        r_bb_pattern <= w_head;
                        r_wdog       <= '0;
                        r_bb_go      <= 1'b1;
                        r_state      <= StGo;
                    end
                    StGo: begin
                        r_wdog <= w_wdog_inc;
                        if (i_bb_busy) begin
                            r_bb_go <= 1'b0;
                            r_state <= StWait;
                        end
                    end
                    StWait: begin
                        r_wdog <= w_wdog_inc;
                        if (i_bb_done) begin
                            r_completed <= r_completed + 16'd1;
                            if (i_gap_cycles != 8'd0) begin
                                r_gap_cnt <= i_gap_cycles - 8'd1;
                                r_state   <= StGap;
                            end else begin
                                r_state <= StNext;
                            end
                        end
                    end
                    StGap: begin
                        if (r_gap_cnt == 8'd0) r_state   <= StNext;
                        else                   r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                    StNext: begin
                        if (!o_fifo_empty) begin
                            r_state <= StLoad;
                        end else begin
                            r_seq_done <= 1'b1;
                            r_state    <= StIdle;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign o_bb_pattern = r_bb_pattern;
    assign o_bb_go      = r_bb_go;
    assign o_bb_reset   = r_bb_reset;
    assign o_active     = (r_state != StIdle);
    assign o_seq_done   = r_seq_done;
    assign o_completed  = r_completed;
    assign o_overflow   = r_overflow;
    assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_jtag_pattern_sequencer.sv
// Scoreboard bench for jtag_pattern_sequencer with a behavioural bit-banger model.
module tb_jtag_pattern_sequencer;

    localparam int unsigned W  = 16;
    localparam int unsigned D  = 8;
    localparam int unsigned TW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [W-1:0]  wr_data;
    logic          start;
    logic          abort;
    logic          clear_status;
    logic [7:0]    gap_cycles;
    logic          bb_busy;
    logic          bb_done;
    logic [W-1:0]  bb_pattern;
    logic          bb_go;
    logic          bb_reset;
    logic [3:0]    fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          active;
    logic          seq_done;
    logic [15:0]   completed;
    logic          overflow;
    logic          timeout;

    int            n_checks = 0;
    int            n_errors = 0;
    int            n_go = 0;
    int            n_seq_done = 0;
    int            n_bb_reset = 0;
    int            bb_latency = 40;
    logic [W-1:0]  sb[$];

    jtag_pattern_sequencer #(
        .pPATTERN_WIDTH (W),
        .pDEPTH         (D),
        .pTIMEOUT_WIDTH (TW)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_wr_en        (wr_en),
        .i_wr_data      (wr_data),
        .i_start        (start),
        .i_abort        (abort),
        .i_clear_status (clear_status),
        .i_gap_cycles   (gap_cycles),
        .i_bb_busy      (bb_busy),
        .i_bb_done      (bb_done),
        .o_bb_pattern   (bb_pattern),
        .o_bb_go        (bb_go),
        .o_bb_reset     (bb_reset),
        .o_fifo_count   (fifo_count),
        .o_fifo_full    (fifo_full),
        .o_fifo_empty   (fifo_empty),
        .o_active       (active),
        .o_seq_done     (seq_done),
        .o_completed    (completed),
        .o_overflow     (overflow),
        .o_timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Bit-banger: busy on go, one-cycle done bb_latency cycles later (0 = never done)
    initial begin
        int cnt;
        bb_busy = 1'b0;
        bb_done = 1'b0;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset || bb_reset) begin
                bb_busy = 1'b0;
                bb_done = 1'b0;
            end else if (bb_done) begin
                bb_done = 1'b0;
                bb_busy = 1'b0;
            end else if (bb_busy) begin
                if (bb_latency != 0) begin
                    cnt++;
                    if (cnt == bb_latency) bb_done = 1'b1;
                end
            end else if (bb_go) begin
                bb_busy = 1'b1;
                cnt = 0;
            end
        end
    end

    // Monitor: each go handshake pops the next expected pattern
    always @(negedge clk) begin
        logic [W-1:0] exp_word;
        if (!reset) begin
            if (bb_go && bb_busy) begin
                n_go++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL go_unexpected: got pattern 0x%0h, required no go", bb_pattern);
                end else begin
                    exp_word = sb.pop_front();
                    check("pattern", 32'(bb_pattern), 32'(exp_word));
                end
            end
            if (seq_done) n_seq_done++;
            if (bb_reset) n_bb_reset++;
        end
    end

    task automatic write_word(input logic [W-1:0] d, input bit accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) sb.push_back(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 500 && !bb_done; i++) @(negedge clk);
        if (!bb_done) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: bb_done not seen within 500 cycles, required a done pulse", name);
        end
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 1000 && active; i++) @(negedge clk);
        if (active) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: still active after 1000 cycles, required idle", name);
        end
        @(negedge clk);
    endtask

    // Cycles from the bb_done sample to the next bb_go sample
    task automatic measure_done_to_go(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bb_go && n < 100);
    endtask

    initial begin
        int n, go0, sd0, rs0;
        reset = 1'b1;
        wr_en = 1'b0;
        wr_data = '0;
        start = 1'b0;
        abort = 1'b0;
        clear_status = 1'b0;
        gap_cycles = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_pattern", 32'(bb_pattern), 0);
        check("rst_go", 32'(bb_go), 0);
        check("rst_bb_reset", 32'(bb_reset), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_empty", 32'(fifo_empty), 1);
        check("rst_full", 32'(fifo_full), 0);
        check("rst_active", 32'(active), 0);
        check("rst_status", 32'({completed, overflow, timeout, seq_done}), 0);
        reset = 1'b0;
        @(negedge clk);

        // Three words, no gap
        sd0 = n_seq_done;
        write_word(16'h0001, 1'b1);
        write_word(16'hE79E, 1'b1);
        write_word(16'hFFFF, 1'b1);
        check("t1_count", 32'(fifo_count), 3);
        pulse_start();
        wait_done("t1_done");
        measure_done_to_go(n);
        check("t1_done_to_go", 32'(n), 3);
        wait_idle("t1_idle");
        check("t1_go_count", 32'(n_go), 3);
        check("t1_completed", 32'(completed), 3);
        check("t1_seq_done", 32'(n_seq_done - sd0), 1);
        check("t1_empty", 32'(fifo_empty), 1);
        check("t1_active", 32'(active), 0);
        check("t1_sb", 32'(sb.size()), 0);

        // Gap of 5 between two words
        gap_cycles = 8'd5;
        write_word(16'h00A5, 1'b1);
        write_word(16'h5A00, 1'b1);
        pulse_start();
        wait_done("gap_done");
        measure_done_to_go(n);
        check("gap_done_to_go", 32'(n), 8);
        wait_idle("gap_idle");
        check("gap_completed", 32'(completed), 2);
        gap_cycles = 8'd0;

        // Overflow: ninth word dropped
        for (int i = 0; i < 9; i++) write_word(16'h1000 + 16'(i), i < 8);
        check("ovf_full", 32'(fifo_full), 1);
        check("ovf_count", 32'(fifo_count), 8);
        check("ovf_flag", 32'(overflow), 1);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);
        go0 = n_go;
        pulse_start();
        wait_idle("ovf_idle");
        check("ovf_go_count", 32'(n_go - go0), 8);
        check("ovf_completed", 32'(completed), 8);
        check("ovf_sb", 32'(sb.size()), 0);

        // Push coinciding with pop at count 4
        write_word(16'hA001, 1'b1);
        write_word(16'hA002, 1'b1);
        write_word(16'hA003, 1'b1);
        write_word(16'hA004, 1'b1);
        pulse_start();
        wait_done("pp_done");
        check("pp_count_before", 32'(fifo_count), 4);
        write_word(16'hA005, 1'b1);
        check("pp_count_after", 32'(fifo_count), 4);
        wait_idle("pp_idle");
        check("pp_completed", 32'(completed), 5);
        check("pp_sb", 32'(sb.size()), 0);

        // Start with an empty FIFO
        go0 = n_go;
        n = 0;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            if (active) n++;
            @(negedge clk);
        end
        check("se_active_cycles", 32'(n), 0);
        check("se_go_count", 32'(n_go - go0), 0);

        // Abort during WAIT of word 2, coinciding with its done
        for (int i = 0; i < 4; i++) write_word(16'hC000 + 16'(i), 1'b1);
        rs0 = n_bb_reset;
        pulse_start();
        wait_done("ab_done1");
        @(negedge clk);
        wait_done("ab_done2");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        sb.delete();
        check("ab_bb_reset", 32'(bb_reset), 1);
        check("ab_count", 32'(fifo_count), 0);
        check("ab_active", 32'(active), 0);
        check("ab_completed", 32'(completed), 1);
        @(negedge clk);
        check("ab_bb_reset_pulse", 32'(bb_reset), 0);
        // Abort while idle still pulses bb_reset
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_idle_bb_reset", 32'(bb_reset), 1);
        @(negedge clk);
        check("ab_reset_pulses", 32'(n_bb_reset - rs0), 2);

        // Watchdog: bit-banger never finishes
        bb_latency = 0;
        sd0 = n_seq_done;
        rs0 = n_bb_reset;
        write_word(16'h0F0F, 1'b1);
        write_word(16'hF0F0, 1'b1);
        pulse_start();
        for (int i = 0; i < 20 && !bb_go; i++) @(negedge clk);
        n = 0;
        while (!timeout && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("to_cycles", 32'(n), 63);
        check("to_flag", 32'(timeout), 1);
        check("to_bb_reset", 32'(bb_reset), 1);
        check("to_count", 32'(fifo_count), 0);
        check("to_active", 32'(active), 0);
        sb.delete();
        repeat (3) @(negedge clk);
        check("to_reset_pulses", 32'(n_bb_reset - rs0), 1);
        check("to_no_seq_done", 32'(n_seq_done - sd0), 0);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        check("to_cleared", 32'(timeout), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit, required completion");
        $fatal(1, "time limit");
    end

endmodule
